// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one single-ported RAM.
// Each access takes IDLE -> ACCESS -> DONE. Data has priority, and a starvation counter bounds how long fetch can be held off.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ifReq,
  input  logic [31:0] i_ifAddr,
  output logic        o_ifAck,
  output logic [31:0] o_ifRdata,
  input  logic        i_memReq,
  input  logic [1:0]  i_memCtrl,
  input  logic [31:0] i_memAddr,
  input  logic [31:0] i_memWdata,
  output logic        o_memAck,
  output logic [31:0] o_memRdata,
  output logic [31:0] o_ramAddr,
  output logic [31:0] o_ramWdata,
  output logic [1:0]  o_ramCtrl,
  input  logic [31:0] i_ramRdata,
  output logic        o_busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]    ctrl_q, ctrl_d, op_q, op_d;
  logic          win_if_q, win_if_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic          starved, grant_if;

  assign starved  = (starve_q == CW'(STARVE_LIMIT));
  assign grant_if = i_ifReq && (!i_memReq || starved);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ctrl_d      = ctrl_q;
    op_d        = op_q;
    win_if_d    = win_if_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (!i_ifReq) starve_d = '0;
        if (i_ifReq || i_memReq) begin
          state_d  = ACCESS;
          win_if_d = grant_if;
          if (grant_if) begin
            addr_d   = i_ifAddr;
            ctrl_d   = 2'b10;
            op_d     = 2'b10;
            starve_d = '0;
          end else begin
            addr_d  = i_memAddr;
            wdata_d = i_memWdata;
            op_d    = i_memCtrl;
            // read+write together is treated as a plain write
            ctrl_d  = (i_memCtrl == 2'b11) ? 2'b01 : i_memCtrl;
            if (i_ifReq && !starved) starve_d = starve_q + CW'(1);
          end
        end
      end
      ACCESS: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        if (win_if_q) begin
          if_rdata_d = i_ramRdata;
        end else begin
          case (op_q)
            2'b10:   mem_rdata_d = i_ramRdata;
            2'b11:   mem_rdata_d = '0;
            default: mem_rdata_d = mem_rdata_q;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      op_q        <= '0;
      win_if_q    <= 1'b0;
      starve_q    <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      op_q        <= op_d;
      win_if_q    <= win_if_d;
      starve_q    <= starve_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Outputs decode straight from the state flop so an async reset kills them at once.
  // Read data is forwarded in the ack cycle; the *_d values equal *_q outside DONE.
  assign o_busy     = (state_q != IDLE);
  assign o_ramCtrl  = (state_q == ACCESS) ? ctrl_q : 2'b00;
  assign o_ramAddr  = addr_q;
  assign o_ramWdata = wdata_q;
  assign o_ifAck    = (state_q == DONE) && win_if_q;
  assign o_memAck   = (state_q == DONE) && !win_if_q;
  assign o_ifRdata  = if_rdata_d;
  assign o_memRdata = mem_rdata_d;

endmodule
